// File: rtl/rv_wb_arbiter_if.sv
// Writeback arbiter bus: issue, ALU, load and regfile write ports.
// slave = arbiter side, master = driver side; RV_WB_BYPASS_EN adds fwd ports.
interface rv_wb_arbiter_if;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic [31:0] o_busy;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_ld_valid;
  logic [4:0]  i_ld_rd;
  logic [31:0] i_ld_data;
  logic        o_ld_ready;
  logic [4:0]  o_rd;
  logic        o_write;
  logic [31:0] o_data;
`ifdef RV_WB_BYPASS_EN
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic        o_fwd1_hit;
  logic        o_fwd2_hit;
  logic [31:0] o_fwd1_data;
  logic [31:0] o_fwd2_data;

  modport slave (
    input  i_issue_valid, i_issue_rd,
    output o_issue_ready, o_busy,
    input  i_alu_valid, i_alu_rd, i_alu_data,
    output o_alu_ready,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    output o_ld_ready,
    output o_rd, o_write, o_data,
    input  i_rs1, i_rs2,
    output o_fwd1_hit, o_fwd2_hit,
    output o_fwd1_data, o_fwd2_data
  );

  modport master (
    output i_issue_valid, i_issue_rd,
    input  o_issue_ready, o_busy,
    output i_alu_valid, i_alu_rd, i_alu_data,
    input  o_alu_ready,
    output i_ld_valid, i_ld_rd, i_ld_data,
    input  o_ld_ready,
    input  o_rd, o_write, o_data,
    output i_rs1, i_rs2,
    input  o_fwd1_hit, o_fwd2_hit,
    input  o_fwd1_data, o_fwd2_data
  );
`else
  modport slave (
    input  i_issue_valid, i_issue_rd,
    output o_issue_ready, o_busy,
    input  i_alu_valid, i_alu_rd, i_alu_data,
    output o_alu_ready,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    output o_ld_ready,
    output o_rd, o_write, o_data
  );

  modport master (
    output i_issue_valid, i_issue_rd,
    input  o_issue_ready, o_busy,
    output i_alu_valid, i_alu_rd, i_alu_data,
    input  o_alu_ready,
    output i_ld_valid, i_ld_rd, i_ld_data,
    input  o_ld_ready,
    input  o_rd, o_write, o_data
  );
`endif
endinterface

// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter + register scoreboard: merges ALU/load into one write port.
// Ports: i_clk, i_reset (async high), bus (slave). Macro: RV_WB_BYPASS_EN.
module rv_wb_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rv_wb_arbiter_if.slave bus
);

  localparam int CW = (STARVE_MAX < 1) ? 1
                    : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic          alu_forced;
  logic          alu_go;
  logic          ld_go;
  logic          issue_ok;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic          wr_q;
  logic [4:0]    rd_q;
  logic [31:0]   data_q;

  always_comb begin
    alu_forced = (starve_cnt == SMAX);
    ld_go      = bus.i_ld_valid && !alu_forced;
    alu_go     = bus.i_alu_valid &&
                 (!bus.i_ld_valid || alu_forced);
    win_rd     = ld_go ? bus.i_ld_rd : bus.i_alu_rd;
    win_data   = ld_go ? bus.i_ld_data : bus.i_alu_data;
    issue_ok   = (bus.i_issue_rd == 5'd0) ||
                 !busy[bus.i_issue_rd];
  end

  // Counter only tracks an ALU that keeps waiting.
  always_comb begin
    starve_nxt = starve_cnt;
    if (alu_go || !bus.i_alu_valid)
      starve_nxt = '0;
    else if (ld_go && starve_cnt != SMAX)
      starve_nxt = starve_cnt + CW'(1);
  end

  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_q)
      busy_nxt[rd_q] = 1'b0;
    if (bus.i_issue_valid && issue_ok &&
        bus.i_issue_rd != 5'd0)
      busy_nxt[bus.i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= '0;
      busy       <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 5'd0;
      data_q     <= 32'd0;
    end else begin
      starve_cnt <= starve_nxt;
      busy       <= busy_nxt;
      if (ld_go || alu_go) begin
        wr_q   <= (win_rd != 5'd0);
        rd_q   <= win_rd;
        data_q <= win_data;
      end else begin
        wr_q <= 1'b0;
      end
    end
  end

  assign bus.o_ld_ready    = ld_go;
  assign bus.o_alu_ready   = alu_go;
  assign bus.o_issue_ready = issue_ok;
  assign bus.o_busy        = busy;
  assign bus.o_write       = wr_q;
  assign bus.o_rd          = rd_q;
  assign bus.o_data        = data_q;

`ifdef RV_WB_BYPASS_EN
  assign bus.o_fwd1_hit  = wr_q && (rd_q == bus.i_rs1) &&
                           (bus.i_rs1 != 5'd0);
  assign bus.o_fwd2_hit  = wr_q && (rd_q == bus.i_rs2) &&
                           (bus.i_rs2 != 5'd0);
  assign bus.o_fwd1_data = data_q;
  assign bus.o_fwd2_data = data_q;
`endif

endmodule
